// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional stall/flush event counters are built when ID_EX_STALL_CNT_EN is defined.
module id_ex_stage #(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [1:0]         id_aluop,
  input  logic               id_branch,
  input  logic               id_memread,
  input  logic               id_memtoreg,
  input  logic               id_memwrite,
  input  logic               id_alusrc,
  input  logic               id_regwrite,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [RADDR_W-1:0] id_rs1,
  input  logic [RADDR_W-1:0] id_rs2,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic [3:0]         id_funct,
  input  logic               flush,
  output logic               stall,
  output logic               ex_valid,
  output logic [1:0]         ex_aluop,
  output logic               ex_branch,
  output logic               ex_memread,
  output logic               ex_memtoreg,
  output logic               ex_memwrite,
  output logic               ex_alusrc,
  output logic               ex_regwrite,
  output logic [XLEN-1:0]    ex_pc,
  output logic [XLEN-1:0]    ex_rs1_data,
  output logic [XLEN-1:0]    ex_rs2_data,
  output logic [XLEN-1:0]    ex_imm,
  output logic [RADDR_W-1:0] ex_rs1,
  output logic [RADDR_W-1:0] ex_rs2,
  output logic [RADDR_W-1:0] ex_rd,
  output logic [3:0]         ex_funct
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
`endif
);

  logic               valid_q, valid_d;
  logic [1:0]         aluop_q, aluop_d;
  logic [5:0]         ctrl_q, ctrl_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]    rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]    imm_q, imm_d;
  logic [RADDR_W-1:0] rs1_q, rs1_d;
  logic [RADDR_W-1:0] rs2_q, rs2_d;
  logic [RADDR_W-1:0] rd_q, rd_d;
  logic [3:0]         funct_q, funct_d;
  logic               capture;
  logic               ctrl_en;

  // Sources are compared regardless of format; x0 never carries a hazard.
  assign stall = id_valid & valid_q & ctrl_q[4] & (rd_q != '0) &
                 ((rd_q == id_rs1) | (rd_q == id_rs2));

  assign capture = ~flush & ~stall;
  assign ctrl_en = capture & id_valid;

  always_comb begin
    valid_d    = ctrl_en;
    aluop_d    = ctrl_en ? id_aluop : 2'b00;
    ctrl_d     = ctrl_en ? {id_branch, id_memread, id_memtoreg,
                            id_memwrite, id_alusrc, id_regwrite} : 6'b0;
    pc_d       = capture ? id_pc       : '0;
    rs1_data_d = capture ? id_rs1_data : '0;
    rs2_data_d = capture ? id_rs2_data : '0;
    imm_d      = capture ? id_imm      : '0;
    rs1_d      = capture ? id_rs1      : '0;
    rs2_d      = capture ? id_rs2      : '0;
    rd_d       = capture ? id_rd       : '0;
    funct_d    = capture ? id_funct    : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      aluop_q    <= '0;
      ctrl_q     <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      aluop_q    <= aluop_d;
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      funct_q    <= funct_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_aluop    = aluop_q;
  assign ex_branch   = ctrl_q[5];
  assign ex_memread  = ctrl_q[4];
  assign ex_memtoreg = ctrl_q[3];
  assign ex_memwrite = ctrl_q[2];
  assign ex_alusrc   = ctrl_q[1];
  assign ex_regwrite = ctrl_q[0];
  assign ex_pc       = pc_q;
  assign ex_rs1_data = rs1_data_q;
  assign ex_rs2_data = rs2_data_q;
  assign ex_imm      = imm_q;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_rd       = rd_q;
  assign ex_funct    = funct_q;

`ifdef ID_EX_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Both counters saturate at all-ones; a flushed stall counts only as a flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !flush && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush && (flush_cnt_q != '1))           flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 5-stage RISC-V core. It sits directly downstream of the decode control unit.
- Each cycle it captures decoded control bits, operands, immediate and register indices into the EX-stage register.
- It contains the load-use hazard detector, which generates the `stall` signal consumed by the control unit, PC and IF/ID.
- It inserts bubbles on stall or flush.

Parameters:
- XLEN, 64, datapath width of operands, immediate and PC.
- RADDR_W, 5, register index width.
- CNT_W, 32, width of the stall cycle counter (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_aluop  in  2  ALUOp from control unit.
- id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite  in  1 each  control bits from control unit.
- id_pc  in  XLEN  PC of ID instruction.
- id_rs1_data, id_rs2_data  in  XLEN  register file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  RADDR_W  register indices.
- id_funct  in  4  {funct7[5], funct3}.
- flush  in  1  branch resolved taken; kill the ID instruction.
- stall  out  1  load-use hazard, combinational.
- ex_valid  out  1  EX holds a real instruction.
- ex_aluop  out  2  registered ALUOp.
- ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite  out  1 each  registered control bits.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered datapath values.
- ex_rs1, ex_rs2, ex_rd  out  RADDR_W  registered indices, used by forwarding.
- ex_funct  out  4  registered funct field.

Behaviour:
- **Reset.** While rst_n is low, all ex_* outputs are 0 and ex_valid is 0. Reset applies immediately, asynchronously. First capture occurs on the first rising edge after rst_n deasserts.
- **Stall equation.** stall = id_valid & ex_valid & ex_memread & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
  - Both sources are compared regardless of instruction format (conservative).
  - stall is purely combinational from the EX register and ID inputs; there is no cycle of latency.
- **Update priority at each rising edge (rst_n high):**
  1. flush = 1: load a bubble. All control bits, ex_aluop and ex_valid are 0; datapath/index fields are 0. flush overrides stall.
  2. else if stall = 1: load a bubble, same as above. The upstream stages hold the ID instruction, so it is re-presented next cycle.
  3. else: capture all id_* into ex_*, with ex_valid = id_valid.
     - If id_valid = 0, all control bits are forced to 0 regardless of inputs.
- **Stall duration.** Exactly one cycle per load-use pair. After the bubble, ex_memread = 0, so stall deasserts and the held instruction captures normally.
- **Back-to-back loads.** A dependent load following a load stalls once, then becomes the new EX load, and can stall its own consumer.
- **x0 is never a hazard.** ld to x0 followed by a reader of x0 gives no stall.
- **Latency.** ID to EX is one cycle; a stall adds one cycle.
- **No state machine beyond the register.** The block is a pipeline register plus hazard logic. Sequential behaviour is bubble insertion and hold interaction.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN.
- **Defined:**
  - Add output `stall_cnt` [CNT_W-1:0], reset to 0, incrementing on every rising edge where stall = 1 and flush = 0.
  - It saturates at all-ones; no wrap.
  - Add output `flush_cnt` [CNT_W-1:0], counting flush edges with the same saturation rule.
- **Undefined:** neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle with ex_regwrite = 1 → all ex_* = 0 immediately, with no clock edge needed. Release → the first edge captures id_*.
- Normal capture: R-type (aluop = 2'b10, regwrite = 1, rs1 = 3, rs2 = 4, rd = 5, rs1_data = 0x10, rs2_data = 0x20) → next edge gives ex_aluop = 2'b10, ex_rd = 5, ex_rs1_data = 0x10, ex_valid = 1, and stall = 0.
- Load-use: ld x7 in EX (ex_memread = 1, ex_rd = 7), then add x8, x7, x1 in ID → stall = 1 that cycle. Next edge: ex_* is a bubble, ex_valid = 0. The following edge captures the add, with stall = 0.
- x0 and no-dependency cases: ld x0 then add rs1 = 0 → stall = 0. ld x7 then add rs1 = 2, rs2 = 3 → stall = 0.
- Flush vs stall: load-use condition present and flush = 1 on the same edge → bubble captured. With ID_EX_STALL_CNT_EN, flush_cnt increments by 1 and stall_cnt is unchanged.
- Counter saturation (ID_EX_STALL_CNT_EN, CNT_W = 4): 20 stall cycles → stall_cnt = 4'hF, holding at 4'hF.
